sam_booth: RTL and testbench
============================

# sam_booth

Parametrised sequential multiplier, the successor to the 8x8 shift-and-add multiplier. It multiplies two N-bit operands, unsigned or two's-complement selectable per operation, using an iterative radix-2 Booth recoding over N+1 bits. It has a fixed, mode-independent latency, a Busy flag, and a one-cycle Done pulse. It sits in the Multiply datapath in place of the 8-bit unit wherever signed products or other widths are needed.

## Interface
- N, default 8: operand width; legal range 2..32; product width is 2N.
- Clock  in  1  rising-edge system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- A  in  N  multiplicand; sampled with Start.
- B  in  N  multiplier; sampled with Start.
- R  out  2N  product; registered; holds the last result until the next completion.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse when R has just been updated.

## Operation
- Reset (Reset_n low, asynchronous): state=IDLE, R=0, Busy=0, Done=0, and all internal registers cleared.
- States:
  - IDLE → RUN when Start=1.
  - RUN → RUN while the iteration count is below N+1.
  - RUN → DONE after iteration N+1.
  - DONE → RUN when Start=1.
  - DONE → IDLE when Start=0.
- On acceptance:
  - Latch A and B extended to N+1 bits: sign-extended if Signed=1, zero-extended if Signed=0.
  - Clear the accumulator, Booth bit q(-1), and the iteration counter.
- Each RUN cycle examines the pair {multiplier LSB, q(-1)}:
  - 01: add the extended multiplicand into the upper half.
  - 10: subtract it.
  - 00 or 11: no operation.
  - Then arithmetic-shift the combined {accumulator, multiplier, q(-1)} right by 1.
- The accumulator is N+2 bits wide so the add/subtract cannot overflow. After N+1 iterations, the low 2N bits of the combined register are the exact product.
- R is loaded with the 2N-bit result on the RUN→DONE transition. R is never modified at any other time except reset.
- Start while Busy=1 is ignored. Operands, Signed, and R are unaffected.
- A and B may change freely after acceptance; they have no effect until the next accepted Start.
- Signed=1 with A or B equal to -2^(N-1) is legal. (-2^(N-1))·(-2^(N-1)) = 2^(2N-2) fits in 2N bits and must be exact.

## Timing
- Start=1 at rising edge k while in IDLE/DONE → Busy=1 from edge k.
- Iterations occur at edges k+1 .. k+N+1.
- At edge k+N+1:
  - R is updated.
  - Done=1 for exactly one cycle, from edge k+N+1 to edge k+N+2.
  - Busy=0.
- Latency is N+1 cycles from the accepting edge to Done, identical for both modes and all operand values (including zero).
- Back-to-back: if Start=1 at the edge ending the Done cycle (edge k+N+2), that operation is accepted. Busy returns to 1 from that edge and Done drops. Throughput is one result per N+2 cycles.
- Reset_n asserted mid-RUN: everything returns to its reset values immediately, with no Done pulse and R=0. The first Start after Reset_n deasserts is accepted normally.
- Done and Busy are never both 1.

## Test plan
- N=8, unsigned: A=12, B=10, Start for one cycle. Required: Done exactly 9 cycles after the accepting edge, R=120, Busy high for exactly 9 cycles.
- N=8, unsigned: A=255, B=250 gives R=63750 (16'hF906). A=150, B=0 gives R=0 with identical latency.
- N=8, signed:
  - A=8'hFD (-3), B=5 gives R=16'hFFF1 (-15).
  - A=8'hFF, B=8'hFA gives R=6.
  - A=B=8'h80 gives R=16'h4000.
- N=8: Start pulsed again 3 cycles into RUN with different operands. Required: ignored; the first result is delivered unchanged on schedule. Then Start held high through Done: the second operation is accepted at the edge after Done, and its result appears N+1 cycles later.
- N=8: Reset_n pulled low 4 cycles into RUN. Required: R=0, Busy=0, Done=0 immediately, and no Done pulse follows. After release, 7·9 gives 63 normally.
- N=16, random sweep of 1000 operand pairs per mode, checked against a reference product. Required: all match, and every Done occurs at exactly 17 cycles.

Source files
------------

// File: rtl/sam_booth.sv
// Sequential N x N multiplier, unsigned or two's-complement per operation.
// Radix-2 Booth recoding over N+1 bits gives a fixed latency of N+1 cycles.
module sam_booth #(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_signed,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_r,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CW = $clog2(N + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N:0]      r_mcand;
  logic [N:0]      r_mplr;
  logic [N+1:0]    r_acc;
  logic            r_q;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_r;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_last;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [N:0]      w_a_ext;
  logic [N:0]      w_b_ext;
  logic [N+1:0]    w_mcand_ext;
  logic [N+1:0]    w_acc_sum;
  logic [N+1:0]    w_acc_sh;
  logic [N:0]      w_mplr_sh;
  logic            w_q_sh;
  logic [2*N-1:0]  w_product;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RUN;
        else         w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_RUN;
      end
      S_DONE: begin
        if (i_start) w_state_nxt = S_RUN;
        else         w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode; flags are computed one cycle ahead so they can be registered
  always_comb begin
    w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    w_last     = (r_cnt == CW'(N));
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (r_state == S_RUN) && w_last;
  end

  // Booth step: add/subtract on the upper half, then arithmetic shift right
  always_comb begin
    if (i_signed) begin
      w_a_ext = {i_a[N-1], i_a};
      w_b_ext = {i_b[N-1], i_b};
    end else begin
      w_a_ext = {1'b0, i_a};
      w_b_ext = {1'b0, i_b};
    end
    w_mcand_ext = {r_mcand[N], r_mcand};
    case ({r_mplr[0], r_q})
      2'b01:   w_acc_sum = r_acc + w_mcand_ext;
      2'b10:   w_acc_sum = r_acc - w_mcand_ext;
      default: w_acc_sum = r_acc;
    endcase
    w_acc_sh  = {w_acc_sum[N+1], w_acc_sum[N+1:1]};
    w_mplr_sh = {w_acc_sum[0], r_mplr[N:1]};
    w_q_sh    = r_mplr[0];
    w_product = {w_acc_sh[N-2:0], w_mplr_sh};
  end

  // Operand latch and iteration datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_ext;
      r_mplr  <= w_b_ext;
      r_acc   <= '0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_sh;
      r_mplr  <= w_mplr_sh;
      r_q     <= w_q_sh;
      r_cnt   <= r_cnt + CW'(1);
    end else begin
      r_acc   <= r_acc;
      r_mplr  <= r_mplr;
    end
  end

  // Registered outputs; R changes only on the final iteration
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt) r_r <= w_product;
      else            r_r <= r_r;
    end
  end

  assign o_r    = r_r;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_sam_booth.sv
// Directed bench for sam_booth: N=8 directed cases plus an N=16 random sweep
// against a reference product, with latency and Busy/Done timing checks.
module tb_sam_booth;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] r16;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  sam_booth #(.N(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_signed(sgn8),
    .i_a(a8), .i_b(b8), .o_r(r8), .o_busy(busy8), .o_done(done8)
  );

  sam_booth #(.N(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_signed(sgn16),
    .i_a(a16), .i_b(b16), .o_r(r16), .o_busy(busy16), .o_done(done16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns cycles until Done (-1 on timeout) and Busy-high samples seen on the way
  task automatic wait_done8(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (busy8) bc++;
      if (done8) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done16(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (busy16) bc++;
      if (done16) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                     input logic [15:0] exp, input string tag);
    int lat, bc;
    a8 = a; b8 = b; sgn8 = sg; start8 = 1'b1;
    step();
    chk({tag, " busy@accept"}, busy8, 1);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; sgn8 = ~sg;
    wait_done8(lat, bc);
    chk({tag, " latency"}, lat, 9);
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " R"}, r8, exp);
    step();
    chk({tag, " done_drop"}, done8, 0);
    chk({tag, " R_hold"}, r8, exp);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sg, input string tag);
    int lat, bc;
    logic signed [31:0] sa, sb;
    logic [31:0] ua, ub, e;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      e  = sa * sb;
    end else begin
      ua = {16'h0000, a};
      ub = {16'h0000, b};
      e  = ua * ub;
    end
    a16 = a; b16 = b; sgn16 = sg; start16 = 1'b1;
    step();
    start16 = 1'b0;
    a16 = $urandom; b16 = $urandom;
    wait_done16(lat, bc);
    chk({tag, " latency"}, lat, 17);
    chk({tag, " R"}, r16, e);
  endtask

  initial begin
    int lat, bc, nd;
    rst_n = 1'b0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start16 = 1'b0; sgn16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    step();
    step();
    chk("reset R", r8, 0);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    rst_n = 1'b1;
    step();

    op8(8'd12,  8'd10,  1'b0, 16'd120,   "u12x10");
    op8(8'd255, 8'd250, 1'b0, 16'hF906,  "u255x250");
    op8(8'd150, 8'd0,   1'b0, 16'h0000,  "u150x0");
    op8(8'hFD,  8'h05,  1'b1, 16'hFFF1,  "s-3x5");
    op8(8'hFF,  8'hFA,  1'b1, 16'h0006,  "s-1x-6");
    op8(8'h80,  8'h80,  1'b1, 16'h4000,  "s-128x-128");

    // Start during RUN is ignored; Start held through Done is accepted after it
    a8 = 8'd12; b8 = 8'd10; sgn8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    a8 = 8'd3; b8 = 8'd3; sgn8 = 1'b1; start8 = 1'b1;
    step();
    a8 = 8'd20; b8 = 8'd5; sgn8 = 1'b0;
    wait_done8(lat, bc);
    chk("ignore latency", lat, 5);
    chk("ignore R", r8, 120);
    step();
    chk("b2b busy", busy8, 1);
    chk("b2b done_drop", done8, 0);
    chk("b2b R_hold", r8, 120);
    start8 = 1'b0;
    wait_done8(lat, bc);
    chk("b2b latency", lat, 9);
    chk("b2b R", r8, 100);
    step();

    // Reset in the middle of RUN
    a8 = 8'd255; b8 = 8'd250; sgn8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst R", r8, 0);
    chk("midrst busy", busy8, 0);
    chk("midrst done", done8, 0);
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) nd++;
    end
    chk("midrst no_done", nd, 0);
    chk("midrst R_after", r8, 0);
    op8(8'd7, 8'd9, 1'b0, 16'd63, "post_rst7x9");

    op16(16'h8000, 16'h8000, 1'b1, "n16 s_min_sq");
    op16(16'hFFFF, 16'hFFFF, 1'b0, "n16 u_max_sq");
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        op16(16'($urandom), 16'($urandom), m[0], m == 0 ? "n16 rand_u" : "n16 rand_s");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
